// File: rtl/wide_add_pkg.sv
// Shared types and sizing helpers for the nibble-serial wide adder sequencer.
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    // Counter/index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int nib_width(input int width);
        return clog2_min1(width / 4);
    endfunction

endpackage

// File: rtl/cla_4_bit.sv
// Registered 4-bit carry-lookahead adder: operands sampled on one edge, sum/carry registered on the next.
module cla_4_bit (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C0,
    output logic [3:0] S,
    output logic       Cout
);

    logic [3:0] a_q;
    logic [3:0] b_q;
    logic       c_q;
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= 1'b0;
        end else begin
            a_q <= A;
            b_q <= B;
            c_q <= C0;
        end
    end

    // Lookahead carries are flattened so no carry ripples between bit positions.
    always_comb begin
        g    = a_q & b_q;
        p    = a_q ^ b_q;
        c[0] = c_q;
        c[1] = g[0] | (p[0] & c_q);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_q);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_q);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            S    <= '0;
            Cout <= 1'b0;
        end else begin
            S    <= p ^ c[3:0];
            Cout <= c[4];
        end
    end

endmodule

// File: rtl/wide_add_sequencer.sv
// Serialises a WIDTH-bit add into 4-bit slices through an external registered CLA,
// chaining the carry LSB-first and presenting the reassembled result over valid/ready.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int ADD_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_s,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int NIB   = WIDTH / 4;
    localparam int NIB_W = nib_width(WIDTH);
    localparam int CNT_W = clog2_min1(ADD_LAT);

    localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(NIB - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADD_LAT - 1);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic               carry;
    logic [NIB_W-1:0]   nib;
    logic [CNT_W-1:0]   cnt;
    logic [NIB_W+1:0]   bit_base;

    assign bit_base = {nib, 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_sum    = '0;
        out_cout   = 1'b0;
        add_a      = '0;
        add_b      = '0;
        add_cin    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                add_a      = a_reg[bit_base +: 4];
                add_b      = b_reg[bit_base +: 4];
                add_cin    = carry;
                state_next = WAIT;
            end
            WAIT: begin
                add_a   = a_reg[bit_base +: 4];
                add_b   = b_reg[bit_base +: 4];
                add_cin = carry;
                if (cnt == '0) begin
                    state_next = (nib == LAST_NIB) ? DONE : ISSUE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_sum   = sum_reg;
                out_cout  = carry;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The adder output is only trusted in the final WAIT cycle; carry feeds the next slice.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            carry   <= 1'b0;
            nib     <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= in_a;
                        b_reg   <= in_b;
                        carry   <= in_cin;
                        nib     <= '0;
                        sum_reg <= '0;
                    end
                end
                ISSUE: begin
                    cnt <= CNT_LOAD;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        sum_reg[bit_base +: 4] <= add_s;
                        carry                  <= add_cout;
                        if (nib != LAST_NIB) begin
                            nib <= nib + NIB_W'(1);
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench: directed requests push hand-computed results, a negedge monitor pops and compares.
module tb_wide_add_sequencer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_s;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_accept = 0;
    logic        prev_valid = 1'b0;
    logic [16:0] exp_q[$];
    logic [16:0] exp_item;
    logic        saw_valid;

    wide_add_sequencer #(.WIDTH(16), .ADD_LAT(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    cla_4_bit u_cla (
        .clk   (clk),
        .reset (reset),
        .A     (add_a),
        .B     (add_b),
        .C0    (add_cin),
        .S     (add_s),
        .Cout  (add_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drive one request and hold it until accepted; optionally register its expected result.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                 input logic [15:0] exp_sum, input logic exp_cout, input bit push);
        int n;
        n        = 0;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        if (push) exp_q.push_back({exp_cout, exp_sum});
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout actual=in_ready 0 expected=in_ready 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout actual=out_valid 0 expected=out_valid 1", name);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (in_valid && in_ready) last_accept = cyc;
            if (out_valid && !prev_valid) checkOutput("latency", 32'(cyc - last_accept), 32'd13);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output actual=%0h expected=no output", out_sum);
                end else begin
                    exp_item = exp_q.pop_front();
                    checkOutput("sum", 32'(out_sum), 32'(exp_item[15:0]));
                    checkOutput("cout", 32'(out_cout), 32'(exp_item[16]));
                end
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=still running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b1;

        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_sum", 32'(out_sum), 32'd0);
        checkOutput("rst_out_cout", 32'(out_cout), 32'd0);
        checkOutput("rst_add_bus", 32'({add_a, add_b, add_cin}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        applyStimulus(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b1);
        waitDone("op1");
        checkOutput("done_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        checkOutput("op1_idle_next", 32'({in_ready, out_valid}), 32'b10);
        @(posedge clk);
        #1;

        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("nib0_bus", 32'({add_a, add_b, add_cin}), 32'({4'hF, 4'h1, 1'b0}));
        for (int i = 1; i < 4; i++) begin
            repeat (3) @(negedge clk);
            checkOutput($sformatf("nib%0d_bus", i), 32'({add_a, add_b, add_cin}), 32'({4'hF, 4'h0, 1'b1}));
        end
        waitDone("op2");
        @(posedge clk);
        #1;

        applyStimulus(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1);
        waitDone("op3");
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        applyStimulus(16'hC000, 16'h4321, 1'b0, 16'h0321, 1'b1, 1'b1);
        waitDone("op4");
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_hold", 32'({out_valid, in_ready, out_cout, out_sum}), 32'({1'b1, 1'b0, 1'b1, 16'h0321}));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        checkOutput("bp_idle_next", 32'({in_ready, out_valid}), 32'b10);
        @(posedge clk);
        #1;

        applyStimulus(16'h1111, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_immediate", 32'({in_ready, out_valid, add_a, add_b, add_cin}), 32'({1'b1, 1'b0, 9'd0}));
        @(posedge clk);
        #1;
        reset = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            saw_valid = saw_valid | out_valid;
        end
        checkOutput("abort_no_valid", 32'(saw_valid), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        applyStimulus(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b1);
        waitDone("op5");
        @(posedge clk);
        #1;

        applyStimulus(16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b1);
        in_a     = 16'hFEDC;
        in_b     = 16'h0124;
        in_cin   = 1'b1;
        in_valid = 1'b1;
        exp_q.push_back({1'b1, 16'h0001});
        waitDone("queued_first");
        checkOutput("queued_not_in_done", 32'(in_ready), 32'd0);
        @(negedge clk);
        checkOutput("queued_accept_next", 32'({in_ready, in_valid}), 32'b11);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waitDone("queued_second");

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
